// File: rtl/sort_serializer.sv
// Serializes one 4-word sorted frame into 4 handshaked beats with a frame counter.
// Optional macro SORT_SERIALIZER_DESC_EN emits beats in descending order (rd..ra).
module sort_serializer #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] ra,
  input  logic [width-1:0] rb,
  input  logic [width-1:0] rc,
  input  logic [width-1:0] rd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [7:0]       frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [width-1:0] word_q [4];
  logic [width-1:0] word_d [4];

  logic beat_acc;
  logic last_acc;
  logic capture;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    beat_acc = (state_q == SEND) && out_ready;
    last_acc = beat_acc && (idx_q == 2'd3);
    in_ready = rst_n && ((state_q == IDLE) || last_acc);
    capture  = in_valid && in_ready;

    if (beat_acc) begin
      if (last_acc) begin
        cnt_d   = cnt_q + 8'd1;
        idx_d   = 2'd0;
        state_d = IDLE;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    // Emission order is fixed at capture time so the output mux never changes.
    if (capture) begin
`ifdef SORT_SERIALIZER_DESC_EN
      word_d[0] = rd;
      word_d[1] = rc;
      word_d[2] = rb;
      word_d[3] = ra;
`else
      word_d[0] = ra;
      word_d[1] = rb;
      word_d[2] = rc;
      word_d[3] = rd;
`endif
      idx_d   = 2'd0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      for (int i = 0; i < 4; i++) word_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 2'd3);
  assign out_data  = out_valid ? word_q[idx_q] : '0;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_sort_serializer.sv
// Self-checking bench for sort_serializer: queue-based reference model plus directed cases.
module tb_sort_serializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] ra, rb, rc, rd;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [7:0]   frame_cnt;

  int checks = 0;
  int errors = 0;

  sort_serializer #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ra(ra), .rb(rb), .rc(rc), .rd(rd),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the held frame is a queue of beats still to be emitted.
  logic [W-1:0] mq[$];
  int           mcnt = 0;

  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = rst_n && (mq.size() == 0 || (out_ready && mq.size() == 1));
    check("m_out_valid", out_valid, mq.size() != 0);
    check("m_in_ready", in_ready, exp_ready);
    check("m_frame_cnt", frame_cnt, mcnt);
    if (mq.size() != 0) begin
      check("m_out_data", out_data, mq[0]);
      check("m_out_idx", out_idx, 4 - mq.size());
      check("m_out_last", out_last, mq.size() == 1);
    end
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      if (mq.size() != 0 && out_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mcnt = (mcnt + 1) % 256;
      end
      if (in_valid && exp_ready) begin
`ifdef SORT_SERIALIZER_DESC_EN
        mq.push_back(rd); mq.push_back(rc); mq.push_back(rb); mq.push_back(ra);
`else
        mq.push_back(ra); mq.push_back(rb); mq.push_back(rc); mq.push_back(rd);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input int a, input int b, input int c, input int d);
    ra = W'(a); rb = W'(b); rc = W'(c); rd = W'(d);
    in_valid = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bexp[4];
    int b2b[8];
    int done;
    bit seen255;
`ifdef SORT_SERIALIZER_DESC_EN
    bexp = '{12, 7, 3, 1};
    b2b  = '{15, 5, 0, 0, 8, 6, 4, 2};
`else
    bexp = '{1, 3, 7, 12};
    b2b  = '{0, 0, 5, 15, 2, 4, 6, 8};
`endif
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ra = '0; rb = '0; rc = '0; rd = '0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;

    // Basic frame, out_ready held high: 4 consecutive beats
    drive_frame(1, 3, 7, 12);
    out_ready = 1'b1;
    @(negedge clk);
    check("basic_in_ready_idle", in_ready, 1);
    check("basic_no_latency0", out_valid, 0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("basic_valid", out_valid, 1);
      check("basic_data", out_data, bexp[i]);
      check("basic_idx", out_idx, i);
      check("basic_last", out_last, i == 3);
      step();
    end
    @(negedge clk);
    check("basic_done_valid", out_valid, 0);
    check("basic_frame_cnt", frame_cnt, 1);

    // Backpressure on beat 1 for 3 cycles
    step();
    drive_frame(1, 3, 7, 12);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_beat0", out_data, bexp[0]);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_data", out_data, bexp[1]);
      check("bp_hold_idx", out_idx, 1);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("bp_data", out_data, bexp[i]);
      step();
    end
    @(negedge clk);
    check("bp_frame_cnt", frame_cnt, 2);

    // Back-to-back frames with in_valid held
    step();
    drive_frame(0, 0, 5, 15);
    step();
    drive_frame(2, 4, 6, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_data", out_data, b2b[i]);
      check("b2b_idx", out_idx, i % 4);
      if (i == 3) check("b2b_in_ready_last", in_ready, 1);
      step();
      if (i == 3) in_valid = 1'b0;
    end
    @(negedge clk);
    check("b2b_frame_cnt", frame_cnt, 4);

    // Reset in the middle of a frame
    step();
    drive_frame(1, 3, 7, 12);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_beat0", out_data, bexp[0]);
    step();
    @(negedge clk);
    check("mid_beat1_idx", out_idx, 1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_valid_after_rst", out_valid, 0);
    check("mid_idx_after_rst", out_idx, 0);
    check("mid_cnt_after_rst", frame_cnt, 0);
    step();
    drive_frame(1, 3, 7, 12);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_restart_valid", out_valid, 1);
    check("mid_restart_idx", out_idx, 0);
    check("mid_restart_data", out_data, bexp[0]);
    repeat (4) step();

    // Counter wrap over 256 back-to-back frames
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    done = 0;
    seen255 = 1'b0;
    for (int c = 0; c < 1200 && done < 256; c++) begin
      @(negedge clk);
      if (done == 255 && !seen255) begin
        check("wrap_cnt_255", frame_cnt, 255);
        seen255 = 1'b1;
      end
      if (out_valid && out_ready && out_last) done++;
      step();
      drive_frame($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("wrap_frames_done", done, 256);
    check("wrap_cnt_0", frame_cnt, 0);
    step();

    // Randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      rc = W'($urandom_range(0, 15));
      rd = W'($urandom_range(0, 15));
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      rst_n     = $urandom_range(0, 199) != 0;
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sort_serializer.md
SORT_SERIALIZER -- requirements
Module: sort_serializer

Interface
REQ-001 The block SHALL have parameter width, default 4, giving the bit width of every data word.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; the reset is synchronous and active-low.
REQ-004 The block SHALL have ports ra, rb, rc, rd, input, width each, the four ascending-sorted words from the sorter stage (ra smallest).
REQ-005 The block SHALL have port in_valid, input, 1, meaning ra..rd hold a valid sorted frame.
REQ-006 The block SHALL have port in_ready, output, 1, meaning a frame is accepted this cycle if in_valid is also high.
REQ-007 The block SHALL have port out_data, output, width, the current serial word.
REQ-008 The block SHALL have port out_idx, output, 2, the position of out_data within its frame (0..3).
REQ-009 The block SHALL have port out_valid, output, 1, meaning out_data, out_idx and out_last are valid.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts the beat when out_valid is high.
REQ-011 The block SHALL have port out_last, output, 1, high with the beat where out_idx = 3.
REQ-012 The block SHALL have port frame_cnt, output, 8, the count of fully emitted frames.

Function
REQ-013 The block SHALL implement two states: IDLE (no frame held) and SEND (frame held, beats pending).
REQ-014 in_ready SHALL be high in IDLE, and in SEND only in the cycle where out_valid && out_ready && out_last.
REQ-015 On in_valid && in_ready the block SHALL register ra..rd into a 4-entry buffer, set out_idx to 0 and enter SEND.
REQ-016 out_valid SHALL rise in the cycle after capture (latency 1); out_valid SHALL equal (state == SEND).
REQ-017 out_data SHALL be the buffered word at position out_idx, driven from registers with no combinational path from ra..rd.
REQ-018 While out_valid && !out_ready, out_data, out_idx and out_last SHALL hold stable.
REQ-019 On out_valid && out_ready with out_idx < 3, out_idx SHALL increment by 1 at the next edge.
REQ-020 On acceptance of the last beat, frame_cnt SHALL increment by 1 and wrap from 255 to 0.
REQ-021 On acceptance of the last beat without a new capture in the same cycle, the state SHALL return to IDLE.
REQ-022 On acceptance of the last beat together with in_valid, the new frame SHALL be captured and the state SHALL stay SEND with out_idx = 0, giving back-to-back frames with no bubble.
REQ-023 in_valid in SEND before the last-beat acceptance SHALL be ignored and the frame SHALL NOT be captured.
REQ-024 A full frame with out_ready held high SHALL take exactly 4 output cycles.

Reset
REQ-025 At a rising clk edge with rst_n low, the state SHALL go to IDLE, with out_valid = 0, out_idx = 0, out_last = 0, out_data = 0, frame_cnt = 0 and all buffer entries = 0.
REQ-026 While rst_n is low, in_ready SHALL be 0.
REQ-027 Reset mid-frame SHALL discard the remaining beats, and frame_cnt SHALL NOT count the dropped frame.

Configuration
REQ-028 With macro SORT_SERIALIZER_DESC_EN defined, beats SHALL be emitted in descending order (rd, rc, rb, ra), and out_idx SHALL still count 0..3 in emission order.
REQ-029 Without SORT_SERIALIZER_DESC_EN, beats SHALL be emitted in ascending order (ra, rb, rc, rd).

Verification
REQ-030 Basic: ra..rd = 1,3,7,12, in_valid for 1 cycle, out_ready = 1 -> out_data 1,3,7,12 on 4 consecutive cycles; out_last on 12; frame_cnt 0 -> 1.
REQ-031 Backpressure: same frame, out_ready low for 3 cycles on beat 1 -> out_data = 3, out_idx = 1 held stable for 3 cycles; in_ready = 0 throughout.
REQ-032 Back-to-back: frame A = 0,0,5,15 then frame B = 2,4,6,8 presented with in_valid held -> 8 consecutive beats 0,0,5,15,2,4,6,8 with no bubble; frame_cnt = 2.
REQ-033 Wrap: emit 256 frames -> frame_cnt reads 255 then 0.
REQ-034 Reset mid-frame: rst_n low after beat 1 -> next cycle out_valid = 0, out_idx = 0, frame_cnt unchanged at 0; a new frame then starts at out_idx = 0.
REQ-035 DESC build: frame 1,3,7,12 with SORT_SERIALIZER_DESC_EN defined -> out_data 12,7,3,1 with out_idx 0..3.
